// File: rtl/spi_ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl_pkg
//   Shared definitions for the SPI-to-RAM command sequencer: opcode values
//   for the 10-bit SPI word, FSM state encoding and address helpers.
//   Imported by the controller RTL and by any block that builds or decodes
//   SPI command words (SPI slave, test bench).
// ---------------------------------------------------------------------------
package spi_ram_ctrl_pkg;

  // SPI word layout: [9:8] opcode, [7:0] payload
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_TX       = 3'd4
  } state_t;

  // depth is carried as 9 bits so that a full 256-word RAM is representable
  function automatic logic addr_in_range(input logic [7:0] addr,
                                         input logic [8:0] depth);
    return ({1'b0, addr} < depth);
  endfunction

  // Post-increment with wrap: (depth-1)+1 -> 0
  function automatic logic [7:0] wrap_inc(input logic [7:0] addr,
                                          input logic [8:0] depth);
    logic [8:0] sum;
    sum = {1'b0, addr} + 9'd1;
    return (sum >= depth) ? 8'd0 : sum[7:0];
  endfunction

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl_if
//   Bundles the SPI word stream, the read-data return path and the RAM port
//   of the command sequencer.
//   master : the sequencer (consumes rx_*, mem_rdata; drives tx_*, mem_*,
//            busy, cmd_err)
//   slave  : the environment (SPI slave + RAM), the mirror image
//   Signals:
//     rx_data[9:0]  SPI word, [9:8] opcode, [7:0] payload
//     rx_valid      SPI word valid (level; may be held)
//     tx_data[7:0]  read data back to the SPI slave
//     tx_valid      tx_data valid
//     mem_addr[7:0] RAM address
//     mem_wdata[7:0]RAM write data
//     mem_we        RAM write strobe
//     mem_re        RAM read strobe
//     mem_rdata[7:0]RAM read data
//     busy          read in flight
//     cmd_err       command rejected pulse
// ---------------------------------------------------------------------------
interface spi_ram_ctrl_if;

  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       cmd_err;

  modport master (
    input  rx_data, rx_valid, mem_rdata,
    output tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re,
           busy, cmd_err
  );

  modport slave (
    output rx_data, rx_valid, mem_rdata,
    input  tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re,
           busy, cmd_err
  );

endinterface

// File: rtl/spi_ram_ctrl_rise_det.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl_rise_det
//   Registered rising-edge detector. rise is high in the first cycle that
//   din is high after having been low; a held-high din gives one pulse only.
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  synchronous active-low reset (delayed copy clears to 0)
//     din    in  level input
//     rise   out din & ~din delayed by one cycle
// ---------------------------------------------------------------------------
module spi_ram_ctrl_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_d_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_d_reg <= 1'b0;
    end else begin
      din_d_reg <= din;
    end
  end

  assign rise = din & ~din_d_reg;

endmodule

// File: rtl/spi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl
//   Command sequencer between an SPI slave and a single-port synchronous RAM.
//   Each accepted 10-bit SPI word is decoded into a register update, a RAM
//   write or a RAM read whose data is returned on tx_data/tx_valid.
//   Parameters:
//     DEPTH      RAM words (<= 256); addresses >= DEPTH are rejected
//     RD_LATENCY cycles from mem_re to valid mem_rdata (1..4)
//     TX_HOLD    cycles tx_valid/tx_data are held for the slave
//     AUTO_INC   1: write/read address post-increment with wrap at DEPTH
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  synchronous active-low reset
//     bus    spi_ram_ctrl_if.master (SPI word in, read data out, RAM port,
//            busy, cmd_err)
// ---------------------------------------------------------------------------
module spi_ram_ctrl #(
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 1,
  parameter int TX_HOLD    = 8,
  parameter bit AUTO_INC   = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_ctrl_if.master bus
);

  import spi_ram_ctrl_pkg::*;

  localparam logic [8:0]        DEPTH_W9  = 9'(DEPTH);
  localparam int                HOLD_W    = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TX_HOLD - 1);
  localparam logic [1:0]        WAIT_LAST = 2'(RD_LATENCY - 1);

  state_t            state_reg, state_next;
  logic [7:0]        wr_addr_reg, wr_addr_next;
  logic [7:0]        rd_addr_reg, rd_addr_next;
  logic              rd_addr_ok_reg, rd_addr_ok_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic [7:0]        mem_addr_reg, mem_addr_next;
  logic [7:0]        mem_wdata_reg, mem_wdata_next;
  logic              cmd_err_reg, cmd_err_next;
  logic [1:0]        wait_cnt_reg, wait_cnt_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

  logic       accept;
  logic       busy_int;
  logic [1:0] op;
  logic [7:0] payload;

  assign op       = bus.rx_data[9:8];
  assign payload  = bus.rx_data[7:0];
  assign busy_int = (state_reg == ST_RD_ISSUE) || (state_reg == ST_RD_WAIT);

  // Only the first cycle of an rx_valid pulse is a command
  spi_ram_ctrl_rise_det u_rise_det (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.rx_valid),
    .rise  (accept)
  );

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next state / datapath ----------------
  always_comb begin
    state_next      = state_reg;
    wr_addr_next    = wr_addr_reg;
    rd_addr_next    = rd_addr_reg;
    rd_addr_ok_next = rd_addr_ok_reg;
    tx_data_next    = tx_data_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    cmd_err_next    = 1'b0;
    wait_cnt_next   = wait_cnt_reg;
    hold_cnt_next   = hold_cnt_reg;

    case (state_reg)
      ST_WR: begin
        state_next = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        state_next    = ST_RD_WAIT;
        wait_cnt_next = WAIT_LAST;
      end
      ST_RD_WAIT: begin
        // last wait cycle is exactly RD_LATENCY cycles after mem_re
        if (wait_cnt_reg == 2'd0) begin
          tx_data_next  = bus.mem_rdata;
          hold_cnt_next = HOLD_LAST;
          state_next    = ST_TX;
        end else begin
          wait_cnt_next = wait_cnt_reg - 2'd1;
        end
      end
      ST_TX: begin
        if (hold_cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
        end
      end
      default: ;
    endcase

    if (accept) begin
      if (busy_int) begin
        // read in flight: drop the command, touch nothing else
        cmd_err_next = 1'b1;
      end else begin
        // from IDLE, WR or TX: any remaining TX hold is abandoned
        state_next = ST_IDLE;
        case (op)
          OP_WR_ADDR: begin
            if (addr_in_range(payload, DEPTH_W9)) begin
              wr_addr_next = payload;
            end else begin
              cmd_err_next = 1'b1;
            end
          end
          OP_WR_DATA: begin
            state_next     = ST_WR;
            mem_addr_next  = wr_addr_reg;
            mem_wdata_next = payload;
            if (AUTO_INC) begin
              wr_addr_next = wrap_inc(wr_addr_reg, DEPTH_W9);
            end
          end
          OP_RD_ADDR: begin
            if (addr_in_range(payload, DEPTH_W9)) begin
              rd_addr_next    = payload;
              rd_addr_ok_next = 1'b1;
            end else begin
              cmd_err_next = 1'b1;
            end
          end
          OP_RD_DATA: begin
            if (rd_addr_ok_reg) begin
              state_next    = ST_RD_ISSUE;
              mem_addr_next = rd_addr_reg;
              // without auto-increment each read needs a fresh address
              if (AUTO_INC) begin
                rd_addr_next = wrap_inc(rd_addr_reg, DEPTH_W9);
              end else begin
                rd_addr_ok_next = 1'b0;
              end
            end else begin
              cmd_err_next = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_reg    <= 8'd0;
      rd_addr_reg    <= 8'd0;
      rd_addr_ok_reg <= 1'b0;
      tx_data_reg    <= 8'd0;
      mem_addr_reg   <= 8'd0;
      mem_wdata_reg  <= 8'd0;
      cmd_err_reg    <= 1'b0;
      wait_cnt_reg   <= 2'd0;
      hold_cnt_reg   <= '0;
    end else begin
      wr_addr_reg    <= wr_addr_next;
      rd_addr_reg    <= rd_addr_next;
      rd_addr_ok_reg <= rd_addr_ok_next;
      tx_data_reg    <= tx_data_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      cmd_err_reg    <= cmd_err_next;
      wait_cnt_reg   <= wait_cnt_next;
      hold_cnt_reg   <= hold_cnt_next;
    end
  end

  // Strobes decode straight from the state, so reset clears them at once
  // and mem_we/mem_re can never coincide.
  assign bus.mem_we    = (state_reg == ST_WR);
  assign bus.mem_re    = (state_reg == ST_RD_ISSUE);
  assign bus.tx_valid  = (state_reg == ST_TX);
  assign bus.busy      = busy_int;
  assign bus.tx_data   = tx_data_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.cmd_err   = cmd_err_reg;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_ram_ctrl
//   Directed test of spi_ram_ctrl. Two instances:
//     dut_a: DEPTH=256, RD_LATENCY=2, TX_HOLD=8, AUTO_INC=0
//     dut_b: DEPTH=16,  RD_LATENCY=1, TX_HOLD=4, AUTO_INC=1
//   Each has a small behavioural RAM with the matching read latency.
//   Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_spi_ram_ctrl;

  import spi_ram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  spi_ram_ctrl_if bus_a ();
  spi_ram_ctrl_if bus_b ();

  spi_ram_ctrl #(
    .DEPTH      (256),
    .RD_LATENCY (2),
    .TX_HOLD    (8),
    .AUTO_INC   (1'b0)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  spi_ram_ctrl #(
    .DEPTH      (16),
    .RD_LATENCY (1),
    .TX_HOLD    (4),
    .AUTO_INC   (1'b1)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // ---------------- RAM models ----------------
  // Non-read cycles load 0xEE so a capture on the wrong cycle shows up.
  logic [7:0] ram_a [256];
  logic [7:0] pipe_a0, pipe_a1;
  logic [7:0] ram_b [16];
  logic [7:0] pipe_b0;

  always @(posedge clk) begin
    if (bus_a.mem_we) ram_a[bus_a.mem_addr] <= bus_a.mem_wdata;
    pipe_a0 <= bus_a.mem_re ? ram_a[bus_a.mem_addr] : 8'hEE;
    pipe_a1 <= pipe_a0;
    if (bus_b.mem_we) ram_b[bus_b.mem_addr[3:0]] <= bus_b.mem_wdata;
    pipe_b0 <= bus_b.mem_re ? ram_b[bus_b.mem_addr[3:0]] : 8'hEE;
  end

  assign bus_a.mem_rdata = pipe_a1;
  assign bus_b.mem_rdata = pipe_b0;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // One-cycle rx_valid pulse; returns in the cycle after acceptance.
  task automatic send(input bit to_b, input logic [1:0] op,
                      input logic [7:0] pl);
    $display("%0t send dut_%s op=%0d payload=0x%02h", $time,
             to_b ? "b" : "a", op, pl);
    if (to_b) begin
      bus_b.rx_data  = {op, pl};
      bus_b.rx_valid = 1'b1;
    end else begin
      bus_a.rx_data  = {op, pl};
      bus_a.rx_valid = 1'b1;
    end
    tick();
    bus_a.rx_valid = 1'b0;
    bus_b.rx_valid = 1'b0;
  endtask

  int cnt;

  initial begin
    rst_n          = 1'b0;
    bus_a.rx_valid = 1'b0;
    bus_a.rx_data  = '0;
    bus_b.rx_valid = 1'b0;
    bus_b.rx_data  = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    check_eq("rst_a_strobes", {bus_a.tx_valid, bus_a.busy, bus_a.mem_we,
             bus_a.mem_re, bus_a.cmd_err}, 5'b0);
    check_eq("rst_a_data", {bus_a.mem_addr, bus_a.mem_wdata, bus_a.tx_data}, 24'h0);
    check_eq("rst_b_strobes", {bus_b.tx_valid, bus_b.busy, bus_b.mem_we,
             bus_b.mem_re, bus_b.cmd_err}, 5'b0);

    // RD_DATA with no read address
    send(1'b0, OP_RD_DATA, 8'h00);
    check_eq("rd_no_addr", {bus_a.cmd_err, bus_a.mem_re}, 2'b10);
    tick();
    check_eq("err_one_cycle", bus_a.cmd_err, 1'b0);

    // write 0xA7 to 0x05
    send(1'b0, OP_WR_ADDR, 8'h05);
    check_eq("wr_addr_ok", {bus_a.cmd_err, bus_a.mem_we}, 2'b00);
    tick();
    send(1'b0, OP_WR_DATA, 8'hA7);
    check_eq("wr_cycle", {bus_a.mem_we, bus_a.mem_re, bus_a.mem_addr, bus_a.mem_wdata},
             {1'b1, 1'b0, 8'h05, 8'hA7});
    tick();
    check_eq("wr_single", {bus_a.mem_we, bus_a.mem_addr}, {1'b0, 8'h05});

    // read back with RD_LATENCY=2: mem_re at N+1, tx_valid N+4..N+11
    send(1'b0, OP_RD_ADDR, 8'h05);
    tick();
    send(1'b0, OP_RD_DATA, 8'h00);
    check_eq("rd_issue", {bus_a.mem_re, bus_a.mem_we, bus_a.busy, bus_a.mem_addr},
             {1'b1, 1'b0, 1'b1, 8'h05});
    tick();
    tick();
    check_eq("rd_not_early", {bus_a.tx_valid, bus_a.busy}, 2'b01);
    tick();
    check_eq("rd_first_tx", {bus_a.tx_valid, bus_a.tx_data}, {1'b1, 8'hA7});
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_a.tx_valid) begin
        cnt++;
        if (bus_a.tx_data !== 8'hA7) cnt += 100;
      end
      tick();
    end
    check_eq("tx_hold_len", cnt, 8);

    // second RD_DATA without a new address
    send(1'b0, OP_RD_DATA, 8'h00);
    check_eq("rd_twice", {bus_a.cmd_err, bus_a.mem_re}, 2'b10);
    tick();

    // WR_DATA with rx_valid held 10 cycles
    send(1'b0, OP_WR_ADDR, 8'h06);
    tick();
    $display("%0t send dut_a op=1 payload=0x3c held", $time);
    bus_a.rx_data  = {OP_WR_DATA, 8'h3C};
    bus_a.rx_valid = 1'b1;
    cnt = 0;
    repeat (10) begin
      tick();
      if (bus_a.mem_we) cnt++;
    end
    bus_a.rx_valid = 1'b0;
    repeat (2) begin
      tick();
      if (bus_a.mem_we) cnt++;
    end
    check_eq("held_one_we", cnt, 1);

    // command during RD_WAIT is dropped, read completes
    send(1'b0, OP_RD_ADDR, 8'h06);
    tick();
    send(1'b0, OP_RD_DATA, 8'h00);
    tick();
    $display("%0t send dut_a op=0 payload=0x10 in rd_wait", $time);
    bus_a.rx_data  = {OP_WR_ADDR, 8'h10};
    bus_a.rx_valid = 1'b1;
    tick();
    bus_a.rx_valid = 1'b0;
    check_eq("busy_drop_err", bus_a.cmd_err, 1'b1);
    tick();
    check_eq("rd_after_drop", {bus_a.tx_valid, bus_a.tx_data}, {1'b1, 8'h3C});
    repeat (9) tick();
    send(1'b0, OP_WR_DATA, 8'h99);
    check_eq("drop_no_change", {bus_a.mem_we, bus_a.mem_addr}, {1'b1, 8'h06});
    tick();

    // reset during TX
    send(1'b0, OP_RD_ADDR, 8'h05);
    tick();
    send(1'b0, OP_RD_DATA, 8'h00);
    repeat (3) tick();
    check_eq("rst_pre_tx", bus_a.tx_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    check_eq("rst_in_tx", {bus_a.tx_valid, bus_a.busy, bus_a.mem_re, bus_a.mem_we,
             bus_a.tx_data}, 12'h0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      tick();
      if (bus_a.tx_valid || bus_a.mem_re || bus_a.mem_we) cnt++;
    end
    check_eq("rst_quiet", cnt, 0);

    // dut_b: DEPTH=16, AUTO_INC=1
    send(1'b1, OP_WR_ADDR, 8'h20);
    check_eq("b_wr_range_err", bus_b.cmd_err, 1'b1);
    tick();
    send(1'b1, OP_WR_DATA, 8'h11);
    check_eq("b_wr_unchanged", {bus_b.mem_we, bus_b.mem_addr}, {1'b1, 8'h00});
    tick();
    send(1'b1, OP_WR_ADDR, 8'h0F);
    check_eq("b_wr_addr_15", bus_b.cmd_err, 1'b0);
    tick();
    send(1'b1, OP_WR_DATA, 8'h55);
    check_eq("b_wr_at_15", {bus_b.mem_we, bus_b.mem_addr, bus_b.mem_wdata},
             {1'b1, 8'h0F, 8'h55});
    tick();
    send(1'b1, OP_WR_DATA, 8'h66);
    check_eq("b_wr_wrap_0", {bus_b.mem_we, bus_b.mem_addr, bus_b.mem_wdata},
             {1'b1, 8'h00, 8'h66});
    tick();
    send(1'b1, OP_RD_ADDR, 8'h10);
    check_eq("b_rd_range_err", bus_b.cmd_err, 1'b1);
    tick();
    send(1'b1, OP_RD_ADDR, 8'h0F);
    tick();
    send(1'b1, OP_RD_DATA, 8'h00);
    check_eq("b_rd_issue", {bus_b.mem_re, bus_b.cmd_err, bus_b.mem_addr},
             {1'b1, 1'b0, 8'h0F});
    tick();
    tick();
    check_eq("b_rd_data", {bus_b.tx_valid, bus_b.tx_data}, {1'b1, 8'h55});
    tick();
    // new RD_DATA in TX: tx drops, read of wrapped address 0 starts
    send(1'b1, OP_RD_DATA, 8'h00);
    check_eq("b_tx_preempt", {bus_b.tx_valid, bus_b.mem_re, bus_b.cmd_err,
             bus_b.mem_addr}, {1'b0, 1'b1, 1'b0, 8'h00});
    tick();
    tick();
    check_eq("b_rd_inc", {bus_b.tx_valid, bus_b.tx_data}, {1'b1, 8'h66});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
